// File: rtl/tft_bus_pkg.sv
// Shared constants, FSM state type and helpers for the 8080-style TFT bus receiver.
// The optional statistics counters are enabled with TFT_BUS_RX_STATS_EN.
package tft_bus_pkg;

   localparam int unsigned H_RES_DEF = 320;
   localparam int unsigned V_RES_DEF = 240;

   localparam logic [7:0] CMD_NOP     = 8'h00;
   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CASET = 3'd1,
      ST_PASET = 3'd2,
      ST_RAMWR = 3'd3,
      ST_SKIP  = 3'd4
   } rx_state_e;

   function automatic logic win_ok(input logic [8:0] sc, input logic [8:0] ec,
                                   input logic [8:0] sp, input logic [8:0] ep,
                                   input logic [9:0] h_lim, input logic [9:0] v_lim);
      return (sc <= ec) && ({1'b0, ec} < h_lim) && (sp <= ep) && ({1'b0, ep} < v_lim);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/tft_bus_sync.sv
// Two-flop synchronisers for the asynchronous TFT bus pins plus WR-rise / RD-fall
// detection; rs/data come out of the same stage as the WR edge so they stay aligned.
module tft_bus_sync
   import tft_bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tft_wr_n,
   input  logic        tft_rd_n,
   input  logic        tft_rs,
   input  logic        tft_reset_n,
   input  logic [15:0] tft_data,
   output logic        wr_stb,
   output logic        rs,
   output logic [15:0] data,
   output logic        rd_stb,
   output logic        preset
);

   logic        wr_meta_q, wr_sync_q, wr_prev_q;
   logic        rd_meta_q, rd_sync_q, rd_prev_q;
   logic        rs_meta_q, rs_sync_q;
   logic        rstn_meta_q, rstn_sync_q;
   logic [15:0] data_meta_q, data_sync_q;

   // synchroniser chains; idle-high strobes reset high so no false edge follows rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_meta_q   <= 1'b1;
         wr_sync_q   <= 1'b1;
         wr_prev_q   <= 1'b1;
         rd_meta_q   <= 1'b1;
         rd_sync_q   <= 1'b1;
         rd_prev_q   <= 1'b1;
         rs_meta_q   <= 1'b0;
         rs_sync_q   <= 1'b0;
         rstn_meta_q <= 1'b1;
         rstn_sync_q <= 1'b1;
         data_meta_q <= 16'h0000;
         data_sync_q <= 16'h0000;
      end else begin
         wr_meta_q   <= tft_wr_n;
         wr_sync_q   <= wr_meta_q;
         wr_prev_q   <= wr_sync_q;
         rd_meta_q   <= tft_rd_n;
         rd_sync_q   <= rd_meta_q;
         rd_prev_q   <= rd_sync_q;
         rs_meta_q   <= tft_rs;
         rs_sync_q   <= rs_meta_q;
         rstn_meta_q <= tft_reset_n;
         rstn_sync_q <= rstn_meta_q;
         data_meta_q <= tft_data;
         data_sync_q <= data_meta_q;
      end
   end

   assign wr_stb = wr_sync_q & ~wr_prev_q & rstn_sync_q;
   assign rd_stb = rd_prev_q & ~rd_sync_q;
   assign rs     = rs_sync_q;
   assign data   = data_sync_q;
   assign preset = ~rstn_sync_q;

endmodule

// File: rtl/tft_bus_receiver.sv
// Decodes the 8080-style TFT command/parameter stream into addressed pixel writes.
// Define TFT_BUS_RX_STATS_EN to add the frame_cnt / drop_cnt statistics outputs.
module tft_bus_receiver
   import tft_bus_pkg::*;
#(
   parameter int unsigned H_RES = H_RES_DEF,
   parameter int unsigned V_RES = V_RES_DEF
)(
   input  logic        clk28,
   input  logic        rst,
   input  logic        tft_wr_n,
   input  logic        tft_rd_n,
   input  logic        tft_rs,
   input  logic        tft_reset_n,
   input  logic [15:0] tft_data,
   output logic        px_valid,
   output logic [8:0]  px_x,
   output logic [8:0]  px_y,
   output logic [15:0] px_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic        win_err,
   output logic        rd_seen
`ifdef TFT_BUS_RX_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
`endif
);

   localparam logic [8:0] EC_DEF = 9'(H_RES - 1);
   localparam logic [8:0] EP_DEF = 9'(V_RES - 1);
   localparam logic [9:0] H_LIM  = 10'(H_RES);
   localparam logic [9:0] V_LIM  = 10'(V_RES);

   logic        sy_wr_stb, sy_rs, sy_rd_stb, sy_preset;
   logic [15:0] sy_data;
   logic        win_valid;

   rx_state_e   state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [8:0]  sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
   logic [8:0]  x_q, x_d, y_q, y_d;
   logic        px_valid_q, px_valid_d;
   logic [8:0]  px_x_q, px_x_d, px_y_q, px_y_d;
   logic [15:0] px_data_q, px_data_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_code_q, cmd_code_d;
   logic        win_err_q, win_err_d;
   logic        rd_seen_q, rd_seen_d;
`ifdef TFT_BUS_RX_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
`endif

   tft_bus_sync u_sync (
      .clk         (clk28),
      .rst         (rst),
      .tft_wr_n    (tft_wr_n),
      .tft_rd_n    (tft_rd_n),
      .tft_rs      (tft_rs),
      .tft_reset_n (tft_reset_n),
      .tft_data    (tft_data),
      .wr_stb      (sy_wr_stb),
      .rs          (sy_rs),
      .data        (sy_data),
      .rd_stb      (sy_rd_stb),
      .preset      (sy_preset)
   );

   assign win_valid = win_ok(sc_q, ec_q, sp_q, ep_q, H_LIM, V_LIM);

   // command decode, window parameter loading and pixel address stepping
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sc_d        = sc_q;
      ec_d        = ec_q;
      sp_d        = sp_q;
      ep_d        = ep_q;
      x_d         = x_q;
      y_d         = y_q;
      px_valid_d  = 1'b0;
      px_x_d      = px_x_q;
      px_y_d      = px_y_q;
      px_data_d   = px_data_q;
      cmd_valid_d = 1'b0;
      cmd_code_d  = cmd_code_q;
      win_err_d   = win_err_q;
      rd_seen_d   = rd_seen_q;
`ifdef TFT_BUS_RX_STATS_EN
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
`endif
      if (sy_preset) begin
         state_d   = ST_IDLE;
         idx_d     = 2'd0;
         sc_d      = 9'd0;
         ec_d      = EC_DEF;
         sp_d      = 9'd0;
         ep_d      = EP_DEF;
         x_d       = 9'd0;
         y_d       = 9'd0;
         win_err_d = 1'b0;
         rd_seen_d = 1'b0;
`ifdef TFT_BUS_RX_STATS_EN
         frame_cnt_d = 16'h0000;
         drop_cnt_d  = 16'h0000;
`endif
      end else begin
         if (sy_rd_stb) begin
            rd_seen_d = 1'b1;
         end else begin
            rd_seen_d = rd_seen_q;
         end
         if (sy_wr_stb && !sy_rs) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = sy_data[7:0];
            case (sy_data[7:0])
               CMD_NOP: begin
                  state_d = state_q;
               end
               CMD_SWRESET: begin
                  state_d = ST_IDLE;
                  idx_d   = 2'd0;
                  sc_d    = 9'd0;
                  ec_d    = EC_DEF;
                  sp_d    = 9'd0;
                  ep_d    = EP_DEF;
                  x_d     = 9'd0;
                  y_d     = 9'd0;
               end
               CMD_CASET: begin
                  state_d = ST_CASET;
                  idx_d   = 2'd0;
               end
               CMD_PASET: begin
                  state_d = ST_PASET;
                  idx_d   = 2'd0;
               end
               CMD_RAMWR: begin
                  state_d = ST_RAMWR;
                  x_d     = sc_q;
                  y_d     = sp_q;
               end
               CMD_RAMWRC: begin
                  state_d = ST_RAMWR;
               end
               default: begin
                  state_d = ST_SKIP;
               end
            endcase
         end else if (sy_wr_stb) begin
            case (state_q)
               ST_CASET, ST_PASET: begin
                  // start/end high bit then low byte, in that order
                  case (idx_q)
                     2'd0: if (state_q == ST_CASET) sc_d[8]   = sy_data[0];
                           else                     sp_d[8]   = sy_data[0];
                     2'd1: if (state_q == ST_CASET) sc_d[7:0] = sy_data[7:0];
                           else                     sp_d[7:0] = sy_data[7:0];
                     2'd2: if (state_q == ST_CASET) ec_d[8]   = sy_data[0];
                           else                     ep_d[8]   = sy_data[0];
                     2'd3: if (state_q == ST_CASET) ec_d[7:0] = sy_data[7:0];
                           else                     ep_d[7:0] = sy_data[7:0];
                     default: idx_d = 2'd0;
                  endcase
                  if (idx_q == 2'd3) begin
                     state_d = ST_IDLE;
                     idx_d   = 2'd0;
                  end else begin
                     idx_d   = idx_q + 2'd1;
                  end
               end
               ST_RAMWR: begin
                  if (win_valid) begin
                     px_valid_d = 1'b1;
                     px_x_d     = x_q;
                     px_y_d     = y_q;
                     px_data_d  = sy_data;
                     if (x_q != ec_q) begin
                        x_d = x_q + 9'd1;
                     end else if (y_q != ep_q) begin
                        x_d = sc_q;
                        y_d = y_q + 9'd1;
                     end else begin
                        x_d = sc_q;
                        y_d = sp_q;
`ifdef TFT_BUS_RX_STATS_EN
                        frame_cnt_d = sat_inc16(frame_cnt_q);
`endif
                     end
                  end else begin
                     win_err_d = 1'b1;
`ifdef TFT_BUS_RX_STATS_EN
                     drop_cnt_d = sat_inc16(drop_cnt_q);
`endif
                  end
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end else begin
            state_d = state_q;
         end
      end
   end

   // decoder state and registered outputs
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         sc_q        <= 9'd0;
         ec_q        <= EC_DEF;
         sp_q        <= 9'd0;
         ep_q        <= EP_DEF;
         x_q         <= 9'd0;
         y_q         <= 9'd0;
         px_valid_q  <= 1'b0;
         px_x_q      <= 9'd0;
         px_y_q      <= 9'd0;
         px_data_q   <= 16'h0000;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= 8'h00;
         win_err_q   <= 1'b0;
         rd_seen_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sc_q        <= sc_d;
         ec_q        <= ec_d;
         sp_q        <= sp_d;
         ep_q        <= ep_d;
         x_q         <= x_d;
         y_q         <= y_d;
         px_valid_q  <= px_valid_d;
         px_x_q      <= px_x_d;
         px_y_q      <= px_y_d;
         px_data_q   <= px_data_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         win_err_q   <= win_err_d;
         rd_seen_q   <= rd_seen_d;
      end
   end

`ifdef TFT_BUS_RX_STATS_EN
   // saturating statistics counters
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= 16'h0000;
         drop_cnt_q  <= 16'h0000;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

   assign px_valid  = px_valid_q;
   assign px_x      = px_x_q;
   assign px_y      = px_y_q;
   assign px_data   = px_data_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign win_err   = win_err_q;
   assign rd_seen   = rd_seen_q;

endmodule

// File: tb/tb_tft_bus_receiver.sv
// Randomised bench for tft_bus_receiver against an arithmetic model of the panel protocol.
// Honours TFT_BUS_RX_STATS_EN for the statistics outputs.
module tb_tft_bus_receiver;

   logic        clk28 = 1'b0;
   logic        rst;
   logic        tft_wr_n, tft_rd_n, tft_rs, tft_reset_n;
   logic [15:0] tft_data;
   logic        px_valid, cmd_valid, win_err, rd_seen;
   logic [8:0]  px_x, px_y;
   logic [15:0] px_data;
   logic [7:0]  cmd_code;
`ifdef TFT_BUS_RX_STATS_EN
   logic [15:0] frame_cnt, drop_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // model: mode 0 idle, 1 column params, 2 page params, 3 pixel writes, 4 skip
   int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_mode, m_idx, m_frames, m_drops;
   bit m_werr, m_rdseen;

   tft_bus_receiver dut (
      .clk28(clk28), .rst(rst), .tft_wr_n(tft_wr_n), .tft_rd_n(tft_rd_n),
      .tft_rs(tft_rs), .tft_reset_n(tft_reset_n), .tft_data(tft_data),
      .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .win_err(win_err), .rd_seen(rd_seen)
`ifdef TFT_BUS_RX_STATS_EN
      , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk28 = ~clk28;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_window_defaults();
      m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
      m_x = 0; m_y = 0; m_mode = 0; m_idx = 0;
   endtask

   task automatic model_word(input bit rs, input logic [15:0] d,
                             output bit exp_px, output int ex, output int ey);
      int hi, lo;
      exp_px = 0; ex = 0; ey = 0;
      hi = int'(d[0]) * 256;
      lo = int'(d[7:0]);
      if (!rs) begin
         case (d[7:0])
            8'h2A: begin m_mode = 1; m_idx = 0; end
            8'h2B: begin m_mode = 2; m_idx = 0; end
            8'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; end
            8'h3C: m_mode = 3;
            8'h01: model_window_defaults();
            8'h00: ;
            default: m_mode = 4;
         endcase
      end else if (m_mode == 1 || m_mode == 2) begin
         if (m_mode == 1) begin
            if (m_idx == 0) m_sc = (m_sc % 256) + hi;
            if (m_idx == 1) m_sc = (m_sc / 256) * 256 + lo;
            if (m_idx == 2) m_ec = (m_ec % 256) + hi;
            if (m_idx == 3) m_ec = (m_ec / 256) * 256 + lo;
         end else begin
            if (m_idx == 0) m_sp = (m_sp % 256) + hi;
            if (m_idx == 1) m_sp = (m_sp / 256) * 256 + lo;
            if (m_idx == 2) m_ep = (m_ep % 256) + hi;
            if (m_idx == 3) m_ep = (m_ep / 256) * 256 + lo;
         end
         m_idx++;
         if (m_idx == 4) begin m_mode = 0; m_idx = 0; end
      end else if (m_mode == 3) begin
         if (m_sc <= m_ec && m_ec < 320 && m_sp <= m_ep && m_ep < 240) begin
            exp_px = 1; ex = m_x; ey = m_y;
            if (m_x != m_ec) m_x = (m_x + 1) % 512;
            else if (m_y != m_ep) begin m_x = m_sc; m_y = (m_y + 1) % 512; end
            else begin
               m_x = m_sc; m_y = m_sp;
               if (m_frames < 65535) m_frames++;
            end
         end else begin
            m_werr = 1;
            if (m_drops < 65535) m_drops++;
         end
      end
   endtask

   task automatic send_word(input bit rs, input logic [15:0] d);
      bit exp_px;
      int ex, ey;
      model_word(rs, d, exp_px, ex, ey);
      @(negedge clk28);
      tft_wr_n = 1'b0; tft_rs = rs; tft_data = d;
      repeat (2) @(negedge clk28);
      tft_wr_n = 1'b1;
      repeat (3) @(posedge clk28);
      #1;
      check_eq("cmd_valid", cmd_valid, !rs);
      if (!rs) check_eq("cmd_code", cmd_code, d[7:0]);
      check_eq("px_valid", px_valid, exp_px);
      if (exp_px) begin
         check_eq("px_x", px_x, ex);
         check_eq("px_y", px_y, ey);
         check_eq("px_data", px_data, d);
      end
      check_eq("win_err", win_err, m_werr);
      check_eq("rd_seen", rd_seen, m_rdseen);
`ifdef TFT_BUS_RX_STATS_EN
      check_eq("frame_cnt", frame_cnt, m_frames);
      check_eq("drop_cnt", drop_cnt, m_drops);
`endif
      @(posedge clk28);
      #1;
      check_eq("px_pulse_len", px_valid, 1'b0);
      check_eq("cmd_pulse_len", cmd_valid, 1'b0);
   endtask

   task automatic rd_pulse();
      @(negedge clk28);
      tft_rd_n = 1'b0;
      repeat (2) @(negedge clk28);
      tft_rd_n = 1'b1;
      repeat (2) @(negedge clk28);
      m_rdseen = 1;
      check_eq("rd_seen_set", rd_seen, 1'b1);
   endtask

   task automatic panel_reset();
      @(negedge clk28);
      tft_reset_n = 1'b0;
      repeat (4) @(negedge clk28);
      tft_reset_n = 1'b1;
      repeat (4) @(negedge clk28);
      model_window_defaults();
      m_werr = 0; m_rdseen = 0; m_frames = 0; m_drops = 0;
      check_eq("preset_win_err", win_err, 1'b0);
      check_eq("preset_rd_seen", rd_seen, 1'b0);
   endtask

   task automatic send_params(input bit is_page, input int a, input int b);
      send_word(1'b0, is_page ? 16'h002B : 16'h002A);
      send_word(1'b1, 16'(a / 256));
      send_word(1'b1, 16'(a % 256));
      send_word(1'b1, 16'(b / 256));
      send_word(1'b1, 16'(b % 256));
   endtask

   initial begin
      int r;
      logic [15:0] d;
      rst = 1'b1; tft_wr_n = 1'b1; tft_rd_n = 1'b1; tft_rs = 1'b0;
      tft_reset_n = 1'b1; tft_data = 16'h0000;
      model_window_defaults();
      m_werr = 0; m_rdseen = 0; m_frames = 0; m_drops = 0;
      repeat (3) @(negedge clk28);
      rst = 1'b0;
      repeat (2) @(negedge clk28);
      check_eq("rst_px_valid", px_valid, 1'b0);
      check_eq("rst_cmd_valid", cmd_valid, 1'b0);
      check_eq("rst_cmd_code", cmd_code, 8'h00);
      check_eq("rst_px_xy", {px_x, px_y}, 18'd0);
      check_eq("rst_px_data", px_data, 16'h0000);
      check_eq("rst_flags", {win_err, rd_seen}, 2'b00);

      // basic RAMWR from the default window origin
      send_word(1'b0, 16'h002C);
      send_word(1'b1, 16'hF800);
      send_word(1'b1, 16'h07E0);
      send_word(1'b1, 16'h001F);
      // continue-write keeps the current address
      send_word(1'b0, 16'h0001);
      send_word(1'b0, 16'h002C);
      send_word(1'b1, 16'h1111);
      send_word(1'b1, 16'h2222);
      send_word(1'b0, 16'h003C);
      send_word(1'b1, 16'h3333);
      // 2x2 window with wrap back to the origin
      send_params(1'b0, 10, 11);
      send_params(1'b1, 5, 6);
      send_word(1'b0, 16'h002C);
      for (int i = 0; i < 5; i++) send_word(1'b1, 16'(16'hA000 + i));
      // command mid-parameter sequence
      send_word(1'b0, 16'h0001);
      send_word(1'b0, 16'h002A);
      send_word(1'b1, 16'h0000);
      send_word(1'b1, 16'h0005);
      send_params(1'b1, 1, 1);
      send_word(1'b0, 16'h002C);
      send_word(1'b1, 16'h5A5A);
      send_word(1'b1, 16'hA5A5);
      // invalid window drops pixels
      send_params(1'b0, 20, 10);
      send_word(1'b0, 16'h002C);
      send_word(1'b1, 16'hBEEF);
      send_word(1'b1, 16'hCAFE);
      // panel reset mid-burst restores defaults and clears flags
      rd_pulse();
      panel_reset();
      send_word(1'b0, 16'h002C);
      send_word(1'b1, 16'h7777);
      rd_pulse();
      send_word(1'b1, 16'h8888);

      // randomised traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         d = 16'($urandom);
         if (r < 6)       begin d[7:0] = 8'h2A; send_word(1'b0, d); end
         else if (r < 12) begin d[7:0] = 8'h2B; send_word(1'b0, d); end
         else if (r < 18) begin d[7:0] = 8'h2C; send_word(1'b0, d); end
         else if (r < 22) begin d[7:0] = 8'h3C; send_word(1'b0, d); end
         else if (r < 24) begin d[7:0] = 8'h01; send_word(1'b0, d); end
         else if (r < 26) begin d[7:0] = 8'h00; send_word(1'b0, d); end
         else if (r < 29) send_word(1'b0, d);
         else if (r < 31) rd_pulse();
         else if (r < 32) panel_reset();
         else begin
            if ((m_mode == 1 || m_mode == 2) && (m_idx % 2 == 0))
               d[0] = ($urandom_range(0, 3) == 0);
            send_word(1'b1, d);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
